// File: rtl/bxn_counter_pkg.sv
// Shared control-path constants for the OptoHybrid trigger chain.
// Used by the FMM stage, the trigger stage and the bunch-crossing counter.
//   LHC_BX_MAX         : last bunch-crossing number of an orbit (wraps to 0)
//   BXN_WIDTH          : width of every bunch-crossing number
//   ERR_CNT_WIDTH      : default width of saturating error counters
//   L0_LATENCY_DEFAULT : nominal counter preset applied on resync
package bxn_counter_pkg;

    localparam int LHC_BX_MAX         = 3563;
    localparam int BXN_WIDTH          = 12;
    localparam int ERR_CNT_WIDTH      = 8;
    localparam int L0_LATENCY_DEFAULT = 160;

endpackage : bxn_counter_pkg

// File: rtl/bxn_counter_sat_counter.sv
// Saturating event counter with synchronous clear.
//   clock : counter clock
//   clr_i : clear to zero; has priority over inc_i
//   inc_i : count one event; holds once all-ones is reached
//   cnt_o : current count
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0] cnt_q;

    always_ff @(posedge clock) begin
        if (clr_i) begin
            cnt_q <= '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign cnt_o = cnt_q;

endmodule : sat_counter

// File: rtl/bxn_counter.sv
// Bunch-crossing counter for the OptoHybrid control path.
// Counts 0..BXN_MAX, is preset to the L0 offset on resync, checks every TTC
// BX0 against the expected count while the FMM stage reports run, and latches
// the count at pre-trigger and at L1A for event headers.
//   clock            : 40 MHz LHC clock
//   reset_i          : synchronous active-high reset, registered once before use
//   ttc_bx0          : TTC BX0 strobe
//   ttc_resync       : TTC resync strobe (preset counter, clear errors)
//   fmm_trig_stop    : 1 = FMM not in run, sync checking suspended
//   bxn_offset       : preset value; values above BXN_MAX load 0
//   sync_err_reset   : clears sticky error flag and error counter
//   trig_pretrig     : pre-trigger strobe, latches bxn into bxn_pretrig
//   ttc_l1a          : L1A strobe, latches bxn into bxn_l1a
//   bxn              : current bunch-crossing number
//   bx0_local        : high in the cycle bxn==0
//   bxn_sync_err     : sticky BX0 misalignment flag
//   bxn_sync_err_cnt : saturating misalignment count
//   bxn_pretrig      : bxn captured at pre-trigger
//   bxn_l1a          : bxn captured at L1A
module bxn_counter
    import bxn_counter_pkg::*;
#(
    parameter int BXN_MAX       = LHC_BX_MAX,
    parameter int BXN_WIDTH     = bxn_counter_pkg::BXN_WIDTH,
    parameter int ERR_CNT_WIDTH = bxn_counter_pkg::ERR_CNT_WIDTH
) (
    input  logic                     clock,
    input  logic                     reset_i,
    input  logic                     ttc_bx0,
    input  logic                     ttc_resync,
    input  logic                     fmm_trig_stop,
    input  logic [BXN_WIDTH-1:0]     bxn_offset,
    input  logic                     sync_err_reset,
    input  logic                     trig_pretrig,
    input  logic                     ttc_l1a,
    output logic [BXN_WIDTH-1:0]     bxn,
    output logic                     bx0_local,
    output logic                     bxn_sync_err,
    output logic [ERR_CNT_WIDTH-1:0] bxn_sync_err_cnt,
    output logic [BXN_WIDTH-1:0]     bxn_pretrig,
    output logic [BXN_WIDTH-1:0]     bxn_l1a
);

    localparam logic [BXN_WIDTH-1:0] BXN_MAX_V = BXN_WIDTH'(BXN_MAX);

    logic                 reset_q;
    logic [BXN_WIDTH-1:0] bxn_q, bxn_d;
    logic [BXN_WIDTH-1:0] offset_eff;
    logic                 bx0_local_q;
    logic                 sync_err_q;
    logic [BXN_WIDTH-1:0] bxn_pretrig_q;
    logic [BXN_WIDTH-1:0] bxn_l1a_q;
    logic                 check_en;
    logic                 misalign;
    logic                 err_clr;

    // An out-of-range preset would leave the counter outside its orbit, so
    // it is replaced by 0.
    always_comb begin
        offset_eff = (bxn_offset <= BXN_MAX_V) ? bxn_offset : '0;
    end

    always_comb begin
        bxn_d = bxn_q + 1'b1;
        if (reset_q || ttc_resync) begin
            bxn_d = offset_eff;
        end else if (bxn_q == BXN_MAX_V) begin
            bxn_d = '0;
        end
    end

    // BX0 is expected exactly when the counter sits at the preset value; a
    // BX0 elsewhere, or no BX0 there, is a misalignment. BX0 never re-aligns
    // the counter, only resync does.
    always_comb begin
        check_en = !reset_q && !ttc_resync && !fmm_trig_stop;
        misalign = check_en && (ttc_bx0 ? (bxn_q != offset_eff)
                                        : (bxn_q == offset_eff));
        err_clr  = reset_q || ttc_resync || sync_err_reset;
    end

    always_ff @(posedge clock) begin
        reset_q <= reset_i;
        if (reset_q) begin
            bxn_q         <= offset_eff;
            bx0_local_q   <= 1'b0;
            sync_err_q    <= 1'b0;
            bxn_pretrig_q <= '0;
            bxn_l1a_q     <= '0;
        end else begin
            bxn_q       <= bxn_d;
            bx0_local_q <= (bxn_d == '0);
            if (err_clr) begin
                sync_err_q <= 1'b0;
            end else if (misalign) begin
                sync_err_q <= 1'b1;
            end
            if (trig_pretrig) begin
                bxn_pretrig_q <= bxn_q;
            end
            if (ttc_l1a) begin
                bxn_l1a_q <= bxn_q;
            end
        end
    end

    sat_counter #(
        .WIDTH (ERR_CNT_WIDTH)
    ) u_err_cnt (
        .clock (clock),
        .clr_i (err_clr),
        .inc_i (misalign),
        .cnt_o (bxn_sync_err_cnt)
    );

    assign bxn          = bxn_q;
    assign bx0_local    = bx0_local_q;
    assign bxn_sync_err = sync_err_q;
    assign bxn_pretrig  = bxn_pretrig_q;
    assign bxn_l1a      = bxn_l1a_q;

endmodule : bxn_counter

// File: doc/bxn_counter.md
Name: bxn_counter

Overview:
- Bunch-crossing counter for the OptoHybrid control path.
- Runs from 0 to BXN_MAX, is preset on resync, and checks every TTC BX0 against the expected count. Checking is active only while the FMM stage reports run, i.e. fmm_trig_stop=0.
- Latches the BXN at pre-trigger and at L1A for event headers.
- Sits directly downstream of the FMM stage: it consumes fmm_trig_stop and shares the TTC BX0/resync strobes.

Parameters:
- BXN_MAX, 3563, last count before wrap to 0.
- BXN_WIDTH, 12, width of all BXN values.
- ERR_CNT_WIDTH, 8, width of the saturating sync-error counter.

Ports:
- clock  in  1  40 MHz LHC clock.
- reset_i  in  1  synchronous, active-high reset; registered one stage internally before use.
- ttc_bx0  in  1  TTC BX0 strobe, one cycle.
- ttc_resync  in  1  TTC resync strobe, one cycle.
- fmm_trig_stop  in  1  1 = FMM not in run; sync checking suspended.
- bxn_offset  in  BXN_WIDTH  preset value loaded on reset/resync (L0 latency, nominally 160).
- sync_err_reset  in  1  clears the sticky error flag and the error counter.
- trig_pretrig  in  1  pre-trigger strobe.
- ttc_l1a  in  1  L1A strobe.
- bxn  out  BXN_WIDTH  current bunch crossing number.
- bx0_local  out  1  high for one cycle when bxn==0.
- bxn_sync_err  out  1  sticky BX0 misalignment flag.
- bxn_sync_err_cnt  out  ERR_CNT_WIDTH  saturating count of misalignments.
- bxn_pretrig  out  BXN_WIDTH  bxn captured at pre-trigger.
- bxn_l1a  out  BXN_WIDTH  bxn captured at L1A.

Behaviour:
- Reset is synchronous and active-high on reset_i, with one internal register stage; "reset" below means the registered reset.
- Reset values: bxn=offset_eff; bx0_local=0; bxn_sync_err=0; bxn_sync_err_cnt=0; bxn_pretrig=0; bxn_l1a=0.
- offset_eff is bxn_offset if bxn_offset ≤ BXN_MAX, otherwise 0. It is sampled combinationally at the time of each load.
- Counter priority per cycle:
  - reset: bxn ← offset_eff
  - else ttc_resync: bxn ← offset_eff
  - else bxn==BXN_MAX: bxn ← 0
  - else bxn ← bxn+1
- Consequence: the cycle after a resync strobe, bxn==offset_eff.
- bx0_local is registered: bx0_local ← (next bxn == 0), so it is coincident with bxn==0.
- A sync check fires only when checking is enabled, i.e. not reset, not ttc_resync, and fmm_trig_stop==0.
- Misalign event: a check fires and either condition holds:
  - ttc_bx0=1 and bxn≠offset_eff (early/late BX0), or
  - ttc_bx0=0 and bxn==offset_eff (missing BX0).
- On a misalign event: bxn_sync_err ← 1, and bxn_sync_err_cnt increments, saturating at all-ones.
- Error flag and counter clear on reset, ttc_resync or sync_err_reset.
- If sync_err_reset coincides with a misalign event, clear wins for that cycle.
- The counter is never re-aligned by BX0; only resync re-aligns it.
- Simultaneous ttc_bx0 and ttc_resync: resync wins; the counter is loaded and no check fires.
- BX0 arriving while fmm_trig_stop=1 is ignored.
- Pre-trigger: if trig_pretrig, bxn_pretrig ← bxn (the value in the strobe cycle). Same for ttc_l1a → bxn_l1a. Latches are independent and may fire together.
- Reset mid-run returns every output to its reset value the cycle after registered reset asserts.
- Latency:
  - strobe → latch/error output: 1 cycle.
  - reset_i → outputs: 2 cycles, due to the reset register.

Decomposition:
- Shared control package holds:
  - LHC_BX_MAX = 3563
  - BXN_WIDTH = 12
  - default L0 latency constant 160
- These are reused by the FMM and trigger stages.
- No sub-module. An optional small saturating-counter sub-module, sat_counter, is natural and reusable for other error counters.

Test Plan:
- Free run: bxn_offset=160, release reset, no BX0.
  - bxn counts 160…3563, 0; bx0_local high exactly when bxn==0.
  - fmm_trig_stop=1 throughout → bxn_sync_err stays 0.
- Aligned run: resync, then BX0 every 3564 cycles, each timed to the cycle where bxn==160, with fmm_trig_stop=0 for 10 orbits.
  - bxn_sync_err=0, bxn_sync_err_cnt=0.
- Misaligned BX0: BX0 at bxn==161.
  - Two events: early/late at 161, missing at 160 → bxn_sync_err=1, cnt=2.
  - sync_err_reset → both 0 next cycle.
- Saturation and priority:
  - 300 misaligned BX0 → cnt=255.
  - BX0 and resync in the same cycle → next bxn=160, no increment.
  - bxn_offset=4000 → resync loads bxn=0.
- Latches: trig_pretrig at bxn=1000, ttc_l1a at bxn=1160, plus simultaneous strobes at 3563.
  - bxn_pretrig=1000, bxn_l1a=1160; then both =3563.
  - reset mid-run → all latches 0, bxn=160.
